// File: rtl/minv_mdiv_seq.sv
// minv_mdiv_seq
// Host-side sequencer for the 256-bit modular inverse/division engine.
// It accepts one command, streams the operands (P, A and, for division, B)
// into the engine one 16-bit word per handshake, and pulses the engine start.
// It then waits for engine ready under a watchdog and streams the selected
// result register back to the host. This block owns every engine strobe.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_op          command request (1 = inverse, 0 = division)
//   cmd_ready                 high only while idle
//   wr_valid/wr_data          operand words, least-significant word first
//   wr_ready                  high while loading P/A/B
//   rd_valid/rd_data/rd_last  result words, least-significant word first
//   rd_ready                  host accepts a result word
//   busy, err                 not idle; sticky watchdog timeout
//   eng_*                     engine data, strobes, mode, taps, ready, flag
module minv_mdiv_seq #(
  parameter int WORDS   = 16,
  parameter int TIMEOUT = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_op,
  output logic        cmd_ready,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic        busy,
  output logic        err,
  output logic [15:0] eng_datain,
  output logic        eng_loadp,
  output logic        eng_loada,
  output logic        eng_loadb,
  output logic        eng_en,
  output logic        eng_minv_mdiv,
  output logic        eng_outx1,
  output logic        eng_outx2,
  input  logic [15:0] eng_x1out,
  input  logic [15:0] eng_x2out,
  input  logic        eng_rdy,
  input  logic        eng_flag
);

  localparam int CW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]  LAST_IDX = CW'(WORDS - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_P,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_READ
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           mode_q, mode_d;
  logic           sel_q, sel_d;
  logic           err_q, err_d;

  logic in_load;
  logic in_read;
  logic wr_fire;
  logic rd_fire;
  logic last_word;

  assign in_load   = (state_q == S_LOAD_P) || (state_q == S_LOAD_A) ||
                     (state_q == S_LOAD_B);
  assign in_read   = (state_q == S_READ);
  assign wr_fire   = in_load && wr_valid;
  assign rd_fire   = in_read && rd_ready;
  assign last_word = (cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d  = cmd_op;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_LOAD_P;
        end
      end

      S_LOAD_P, S_LOAD_A, S_LOAD_B: begin
        if (wr_fire) begin
          if (last_word) begin
            cnt_d = '0;
            // Inverse mode has no B operand, so it goes straight to start.
            if (state_q == S_LOAD_P) begin
              state_d = S_LOAD_A;
            end else if ((state_q == S_LOAD_A) && !mode_q) begin
              state_d = S_LOAD_B;
            end else begin
              state_d = S_START;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // wd_q == 0 marks the first WAIT cycle: a ready still high from the
        // previous operation is ignored there. The watchdog never returns
        // to zero inside WAIT because it saturates.
        if ((wd_q != '0) && eng_rdy) begin
          sel_d   = eng_flag;
          cnt_d   = '0;
          state_d = S_READ;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + WDW'(1);
        end
      end

      S_READ: begin
        if (rd_fire) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      mode_q  <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // Host-facing status decoded from the registered state.
  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign wr_ready      = in_load;
  assign rd_valid      = in_read;
  assign rd_last       = in_read && last_word;
  assign err           = err_q;

  // Data paths are forced to zero outside their phases so idle/reset
  // outputs stay quiet regardless of what the host or engine drives.
  assign eng_datain    = in_load ? wr_data : 16'h0000;
  assign rd_data       = in_read ? (sel_q ? eng_x2out : eng_x1out) : 16'h0000;

  // Engine strobes: at most one per cycle, each qualified by its handshake.
  assign eng_loadp     = (state_q == S_LOAD_P) && wr_valid;
  assign eng_loada     = (state_q == S_LOAD_A) && wr_valid;
  assign eng_loadb     = (state_q == S_LOAD_B) && wr_valid;
  assign eng_en        = (state_q == S_START);
  assign eng_outx1     = rd_fire && !sel_q;
  assign eng_outx2     = rd_fire && sel_q;
  assign eng_minv_mdiv = mode_q;

endmodule

// File: tb/tb_minv_mdiv_seq.sv
module tb_minv_mdiv_seq;

  localparam int WORDS = 16;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_op, cmd_ready;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_last, rd_ready;
  logic [15:0] rd_data;
  logic        busy, err;
  logic [15:0] eng_datain;
  logic        eng_loadp, eng_loada, eng_loadb, eng_en, eng_minv_mdiv;
  logic        eng_outx1, eng_outx2;
  logic [15:0] eng_x1out, eng_x2out;
  logic        eng_rdy, eng_flag;

  always #5 clk = ~clk;

  minv_mdiv_seq #(.WORDS(WORDS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .err(err),
    .eng_datain(eng_datain), .eng_loadp(eng_loadp), .eng_loada(eng_loada),
    .eng_loadb(eng_loadb), .eng_en(eng_en), .eng_minv_mdiv(eng_minv_mdiv),
    .eng_outx1(eng_outx1), .eng_outx2(eng_outx2),
    .eng_x1out(eng_x1out), .eng_x2out(eng_x2out),
    .eng_rdy(eng_rdy), .eng_flag(eng_flag)
  );

  // ---------------- behavioural engine model ----------------
  logic [15:0] x1_mem [WORDS];
  logic [15:0] x2_mem [WORDS];
  logic [15:0] p_got [64];
  logic [15:0] a_got [64];
  logic [15:0] b_got [64];
  int  np = 0, na = 0, nb = 0, nen = 0, nx1 = 0, nx2 = 0, viol = 0;
  int  cyc = 0, en_cyc = 0, tcnt = 0;
  logic running = 1'b0, done = 1'b0;
  int  rdy_delay;
  bit  rdy_force, model_clr, cur_op, flag_drv;
  int  vbad_now;
  logic [3:0] ix1, ix2;

  assign ix1       = nx1[3:0];
  assign ix2       = nx2[3:0];
  assign eng_x1out = x1_mem[ix1];
  assign eng_x2out = x2_mem[ix2];
  assign eng_rdy   = done | rdy_force;
  assign eng_flag  = flag_drv;

  always_comb begin
    vbad_now = 0;
    if (int'(eng_loadp) + int'(eng_loada) + int'(eng_loadb) + int'(eng_outx1) + int'(eng_outx2) > 1)
      vbad_now = vbad_now + 1;
    if ((eng_loadp || eng_loada || eng_loadb) && !(wr_valid && wr_ready)) vbad_now = vbad_now + 1;
    if ((eng_outx1 || eng_outx2) && !(rd_valid && rd_ready)) vbad_now = vbad_now + 1;
    if (eng_loada && np != WORDS) vbad_now = vbad_now + 1;
    if (eng_loadb && na != WORDS) vbad_now = vbad_now + 1;
    if (eng_en && (na != WORDS || nb != (cur_op ? 0 : WORDS))) vbad_now = vbad_now + 1;
    if ((eng_outx1 || eng_outx2) && nen != 1) vbad_now = vbad_now + 1;
    if (busy && (eng_minv_mdiv != cur_op)) vbad_now = vbad_now + 1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (model_clr) begin
      np <= 0; na <= 0; nb <= 0; nen <= 0; nx1 <= 0; nx2 <= 0; viol <= 0;
    end else begin
      viol <= viol + vbad_now;
      if (eng_loadp) begin if (np < 64) p_got[np] <= eng_datain; np <= np + 1; end
      if (eng_loada) begin if (na < 64) a_got[na] <= eng_datain; na <= na + 1; end
      if (eng_loadb) begin if (nb < 64) b_got[nb] <= eng_datain; nb <= nb + 1; end
      if (eng_outx1) nx1 <= nx1 + 1;
      if (eng_outx2) nx2 <= nx2 + 1;
    end
    // Ready rises rdy_delay cycles after the start pulse; 0 means never.
    if (eng_en) begin
      nen     <= nen + 1;
      en_cyc  <= cyc;
      done    <= 1'b0;
      tcnt    <= 0;
      running <= (rdy_delay > 0);
    end else if (running) begin
      tcnt <= tcnt + 1;
      if (tcnt + 1 == rdy_delay) begin
        done    <= 1'b1;
        running <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_strobes"},
        32'({eng_loadp, eng_loada, eng_loadb, eng_en, eng_outx1, eng_outx2, rd_last}), 32'd0);
    chk({tag, "_mode"}, 32'(eng_minv_mdiv), 32'd0);
  endtask

  typedef struct {
    string name;
    bit    op;
    bit    flag;
    int    delay;
    bit    wr_gap;
    bit    rd_gap;
    bit    stale;
    int    exp_nb;
    bit    exp_err;
  } vec_t;

  task automatic run_cmd(input string name, input bit op, input bit flag, input int delay,
                         input bit wr_gap, input bit rd_gap, input bit stale,
                         input int abort_load, input int abort_read,
                         input int exp_nb, input bit exp_err);
    logic [15:0] ops [48];
    logic [15:0] rdw [WORDS];
    logic [15:0] want;
    int nw, sent, guard, got, errs0;
    bit lastbad;
    errs0 = errors;
    nw = op ? 2 * WORDS : 3 * WORDS;
    for (int i = 0; i < 48; i++) ops[i] = 16'($urandom);
    for (int i = 0; i < WORDS; i++) begin
      x1_mem[i] = 16'($urandom);
      x2_mem[i] = 16'($urandom);
    end
    flag_drv = flag; rdy_delay = delay; cur_op = op;
    model_clr = 1'b1;
    @(posedge clk); #1;
    model_clr = 1'b0;

    chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 1'($urandom);
    chk({name, "_wr_ready_n1"}, 32'(wr_ready), 32'd1);
    chk({name, "_err_cleared"}, 32'(err), 32'd0);
    chk({name, "_mode"}, 32'(eng_minv_mdiv), 32'(op));

    rdy_force = stale;
    sent = 0; guard = 0;
    while (sent < nw && guard < 2000) begin
      wr_valid = wr_gap ? ($urandom % 3 != 0) : 1'b1;
      wr_data  = wr_valid ? ops[sent] : 16'($urandom);
      if (abort_load >= 0 && sent == abort_load) begin
        wr_valid = 1'b1; wr_data = ops[sent];
        #3 rst = 1'b1;
        #1 chk_quiet_reset({name, "_rstload"});
        @(posedge clk); #1;
        rst = 1'b0; wr_valid = 1'b0; rdy_force = 1'b0;
        $display("CMD %s aborted by reset at load word %0d, errors in cmd %0d", name, sent, errors - errs0);
        return;
      end
      @(posedge clk); #1;
      if (wr_valid) sent++;
      guard++;
    end
    wr_valid = 1'b0;
    chk({name, "_load_count"}, 32'(sent), 32'(nw));
    chk({name, "_en_after_last"}, 32'(eng_en), 32'd1);

    if (stale) begin
      @(posedge clk); #1;   // first WAIT cycle, ready still forced high
      @(posedge clk); #1;
      rdy_force = 1'b0;
    end

    guard = 0;
    while (!rd_valid && busy && guard < TMO + 20) begin
      @(posedge clk); #1;
      guard++;
    end

    if (exp_err) begin
      chk({name, "_to_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({name, "_to_idle"}, 32'(cmd_ready), 32'd1);
      chk({name, "_to_err"}, 32'(err), 32'd1);
      chk({name, "_to_cycles"}, 32'(cyc - en_cyc), 32'(TMO + 1));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk({name, "_err_sticky"}, 32'(err), 32'd1);
      chk({name, "_to_no_read"}, 32'(nx1 + nx2), 32'd0);
      $display("CMD %s op=%0d timeout, errors in cmd %0d", name, op, errors - errs0);
      return;
    end

    chk({name, "_rd_valid"}, 32'(rd_valid), 32'd1);
    chk({name, "_rdy_latency"}, 32'(cyc - en_cyc), 32'(delay + 2));

    got = 0; guard = 0; lastbad = 1'b0;
    while (got < WORDS && guard < 2000) begin
      rd_ready = rd_gap ? ($urandom % 3 != 0) : 1'b1;
      if (abort_read >= 0 && got == abort_read) begin
        rd_ready = 1'b1;
        #3 rst = 1'b1;
        #1 chk_quiet_reset({name, "_rstread"});
        chk({name, "_rstread_data"}, 32'(rd_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; rd_ready = 1'b0;
        $display("CMD %s aborted by reset at read word %0d, errors in cmd %0d", name, got, errors - errs0);
        return;
      end
      if (rd_valid && (rd_last != (got == WORDS - 1))) lastbad = 1'b1;
      if (rd_valid && rd_ready) begin
        rdw[got] = rd_data;
        got++;
      end
      @(posedge clk); #1;
      guard++;
    end
    rd_ready = 1'b0;

    chk({name, "_rd_count"}, 32'(got), 32'(WORDS));
    for (int i = 0; i < WORDS; i++) begin
      want = flag ? x2_mem[i] : x1_mem[i];
      chk({name, "_rd_word"}, {16'(i), rdw[i]}, {16'(i), want});
    end
    chk({name, "_rd_last"}, 32'(lastbad), 32'd0);
    chk({name, "_back_idle"}, 32'({cmd_ready, busy}), 32'b10);
    chk({name, "_n_loadp"}, 32'(np), 32'(WORDS));
    chk({name, "_n_loada"}, 32'(na), 32'(WORDS));
    chk({name, "_n_loadb"}, 32'(nb), 32'(exp_nb));
    chk({name, "_n_en"}, 32'(nen), 32'd1);
    chk({name, "_n_outx1"}, 32'(nx1), flag ? 32'd0 : 32'(WORDS));
    chk({name, "_n_outx2"}, 32'(nx2), flag ? 32'(WORDS) : 32'd0);
    chk({name, "_violations"}, 32'(viol), 32'd0);
    for (int i = 0; i < WORDS; i++) begin
      chk({name, "_p_word"}, {16'(i), p_got[i]}, {16'(i), ops[i]});
      chk({name, "_a_word"}, {16'(i), a_got[i]}, {16'(i), ops[WORDS + i]});
      if (!op) chk({name, "_b_word"}, {16'(i), b_got[i]}, {16'(i), ops[2 * WORDS + i]});
    end
    $display("CMD %s op=%0d flag=%0d delay=%0d words=%0d, errors in cmd %0d",
             name, op, flag, delay, nw, errors - errs0);
  endtask

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{"inv_basic",   1'b1, 1'b1, 60, 1'b0, 1'b0, 1'b0, 0,     1'b0};
    vecs[1] = '{"div_basic",   1'b0, 1'b0, 30, 1'b0, 1'b0, 1'b0, WORDS, 1'b0};
    vecs[2] = '{"inv_x1",      1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b0, 0,     1'b0};
    vecs[3] = '{"div_bp",      1'b0, 1'b1, 10, 1'b1, 1'b1, 1'b0, WORDS, 1'b0};
    vecs[4] = '{"stale_rdy",   1'b1, 1'b1, 50, 1'b0, 1'b0, 1'b1, 0,     1'b0};
    vecs[5] = '{"min_wait",    1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, WORDS, 1'b0};
    vecs[6] = '{"timeout",     1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b0, 0,     1'b1};
    vecs[7] = '{"after_to",    1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b0, WORDS, 1'b0};
    vecs[8] = '{"near_to",     1'b1, 1'b1, 62, 1'b0, 1'b0, 1'b0, 0,     1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b1; wr_valid = 1'b0; wr_data = 16'hA5A5;
    rd_ready = 1'b0; rdy_force = 1'b0; model_clr = 1'b0; cur_op = 1'b0; flag_drv = 1'b1;
    rdy_delay = 0;
    for (int i = 0; i < WORDS; i++) begin
      x1_mem[i] = 16'h1234;
      x2_mem[i] = 16'h5678;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_quiet_reset("reset");
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_datain", 32'(eng_datain), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    #2 rst = 1'b0;

    foreach (vecs[k])
      run_cmd(vecs[k].name, vecs[k].op, vecs[k].flag, vecs[k].delay, vecs[k].wr_gap,
              vecs[k].rd_gap, vecs[k].stale, -1, -1, vecs[k].exp_nb, vecs[k].exp_err);

    // Reset corner cases, each followed by a clean inverse command.
    run_cmd("rst_load", 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b0, 7, -1, 0, 1'b0);
    run_cmd("post_rst1", 1'b1, 1'b1, 25, 1'b0, 1'b0, 1'b0, -1, -1, 0, 1'b0);
    run_cmd("rst_read", 1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0, -1, 5, WORDS, 1'b0);
    run_cmd("post_rst2", 1'b1, 1'b0, 12, 1'b0, 1'b0, 1'b0, -1, -1, 0, 1'b0);

    // Randomised commands; expected load-B count follows from the mode.
    for (int r = 0; r < 6; r++) begin
      bit rop, rflag;
      rop   = 1'($urandom);
      rflag = 1'($urandom);
      run_cmd("random", rop, rflag, $urandom_range(1, 60), 1'($urandom), 1'($urandom),
              1'b0, -1, -1, rop ? 0 : WORDS, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
